// File: rtl/ann_layer_if.sv
// Request/result bundle for ann_layer: operand vectors, start/ready/done handshake and packed results.
interface ann_layer_if #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int DW = 8
);
  logic              start;
  logic              relu_en;
  logic [N*DW-1:0]   InputVec;
  logic [M*N*DW-1:0] WeightVec;
  logic [M*DW-1:0]   BiasVec;
  logic [M*16-1:0]   Result;
  logic              ready;
  logic              done;

  modport master (
    output start, relu_en, InputVec, WeightVec, BiasVec,
    input  Result, ready, done
  );

  modport slave (
    input  start, relu_en, InputVec, WeightVec, BiasVec,
    output Result, ready, done
  );
endinterface

// File: rtl/ann_layer.sv
// Fully-connected neuron layer: M parallel signed MACs over N inputs, bias preload,
// 16-bit saturation and optional ReLU; one input element consumed per cycle.
module ann_layer #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int DW = 8
) (
  input logic       clk,
  input logic       rst,
  ann_layer_if.slave bus
);
  localparam int AW = 2*DW + $clog2(N) + 1;
  localparam int EW = (AW > 17) ? AW : 17;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]        LAST = IW'(N-1);
  localparam logic signed [EW-1:0] SMAX = EW'(32767);
  localparam logic signed [EW-1:0] SMIN = EW'(-32768);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state;
  logic [IW-1:0]          index;
  logic                   relu_r;
  logic                   ready_r;
  logic                   done_r;
  logic [M*16-1:0]        result_r;
  logic signed [DW-1:0]   x_r [N];
  logic signed [DW-1:0]   w_r [M][N];
  logic signed [AW-1:0]   acc [M];
  logic signed [2*DW-1:0] prod [M];
  logic signed [EW-1:0]   ext [M];
  logic [15:0]            sat [M];

  always_comb begin
    for (int unsigned j = 0; j < M; j++) begin
      prod[j] = x_r[index] * w_r[j][index];
      // Widen to at least 17 bits so the clamp bounds are representable for tiny DW/N.
      ext[j]  = EW'(acc[j]);
      if (ext[j] > SMAX)
        sat[j] = 16'h7FFF;
      else if (ext[j] < SMIN)
        sat[j] = 16'h8000;
      else
        sat[j] = ext[j][15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      index    <= '0;
      relu_r   <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      result_r <= '0;
      for (int unsigned j = 0; j < M; j++) acc[j] <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            for (int unsigned i = 0; i < N; i++)
              x_r[i] <= bus.InputVec[(N-1-i)*DW +: DW];
            for (int unsigned j = 0; j < M; j++) begin
              for (int unsigned i = 0; i < N; i++)
                w_r[j][i] <= bus.WeightVec[(M*N-1-(j*N+i))*DW +: DW];
              acc[j] <= AW'($signed(bus.BiasVec[(M-1-j)*DW +: DW]));
            end
            relu_r  <= bus.relu_en;
            index   <= '0;
            ready_r <= 1'b0;
            state   <= MAC;
          end
        end
        MAC: begin
          for (int unsigned j = 0; j < M; j++)
            acc[j] <= acc[j] + AW'(prod[j]);
          index <= index + 1'b1;
          if (index == LAST) state <= OUT;
        end
        OUT: begin
          for (int unsigned j = 0; j < M; j++)
            result_r[(M-1-j)*16 +: 16] <= (relu_r && sat[j][15]) ? '0 : sat[j];
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.done   = done_r;
  assign bus.Result = result_r;
endmodule

// File: tb/tb_ann_layer.sv
// Directed bench for ann_layer: cycle-level transaction model compared every cycle,
// plus hand-computed result literals.
module tb_ann_layer;
  localparam int N  = 2;
  localparam int M  = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ann_layer_if #(.N(N), .M(M), .DW(DW)) bus ();
  ann_layer #(.N(N), .M(M), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: dot product + bias in plain integers, clamp, optional ReLU.
  function automatic logic [M*16-1:0] model_eval(input logic [N*DW-1:0] xv,
      input logic [M*N*DW-1:0] wv, input logic [M*DW-1:0] bv, input logic relu);
    logic [M*16-1:0] r;
    logic [DW-1:0] f;
    int s;
    r = '0;
    for (int j = 0; j < M; j++) begin
      f = bv[(M-1-j)*DW +: DW];
      s = int'($signed(f));
      for (int i = 0; i < N; i++) begin
        int xi, wi;
        f  = xv[(N-1-i)*DW +: DW];
        xi = int'($signed(f));
        f  = wv[(M*N-1-(j*N+i))*DW +: DW];
        wi = int'($signed(f));
        s += xi * wi;
      end
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      r[(M-1-j)*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  // Transaction-timing model: an accepted start yields done N+1 edges later.
  bit              mvalid = 0;
  bit              busy   = 0;
  int              cyc    = 0;
  int              due    = 0;
  logic [M*16-1:0] pending;
  logic [M*16-1:0] exp_result;
  logic            exp_done;
  logic            exp_ready;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mvalid = 1; busy = 0; exp_done = 0; exp_ready = 1; exp_result = '0;
    end else if (mvalid) begin
      exp_done = 0;
      if (!busy && bus.start) begin
        pending = model_eval(bus.InputVec, bus.WeightVec, bus.BiasVec, bus.relu_en);
        busy = 1;
        due  = cyc + N + 1;
      end else if (busy && cyc == due) begin
        exp_result = pending;
        exp_done   = 1;
        busy       = 0;
      end
      exp_ready = !busy;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("ready", 32'(bus.ready), 32'(exp_ready));
      check("done", 32'(bus.done), 32'(exp_done));
      check("result", bus.Result, exp_result);
    end
  end

  task automatic set_vec(input int x0, x1, w00, w01, w10, w11, b0, b1, input logic relu);
    bus.InputVec  = {8'(x0), 8'(x1)};
    bus.WeightVec = {8'(w00), 8'(w01), 8'(w10), 8'(w11)};
    bus.BiasVec   = {8'(b0), 8'(b1)};
    bus.relu_en   = relu;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1; break; end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic run(input string name);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_done(name);
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    rst = 1'b0;

    set_vec(3, 4, 2, 5, -1, -1, 1, 0, 1'b0);
    run("basic");
    check("basic_lit", bus.Result, 32'h001B_FFF9);
    check("basic_model", exp_result, 32'h001B_FFF9);

    set_vec(3, 4, 2, 5, -1, -1, 1, 0, 1'b1);
    run("relu");
    check("relu_lit", bus.Result, 32'h001B_0000);

    set_vec(-128, -128, -128, -128, 1, 1, 127, 0, 1'b0);
    run("sat");
    check("sat_lit", bus.Result, 32'h7FFF_FF00);

    // start pulsed during MAC must not queue a second evaluation
    set_vec(3, 4, 2, 5, -1, -1, 1, 0, 1'b0);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("ignore_start_dones", 32'(cnt), 32'd1);

    // back-to-back: start raised in the done cycle
    run("b2b_first");
    bus.start = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin cnt = k; break; end
    end
    check("b2b_spacing", 32'(cnt), 32'd4);

    // inputs changed after the capture edge are not used
    set_vec(3, 4, 2, 5, -1, -1, 1, 0, 1'b0);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.InputVec = {8'd100, 8'd100};
    wait_done("capture");
    check("capture_lit", bus.Result, 32'h001B_FFF9);

    // reset mid-MAC abandons the evaluation
    set_vec(10, 10, 10, 10, 10, 10, 0, 0, 1'b0);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("rst_mid_dones", 32'(cnt), 32'd0);
    check("rst_mid_result", bus.Result, 32'd0);
    check("rst_mid_ready", 32'(bus.ready), 32'd1);
    set_vec(3, 4, 2, 5, -1, -1, 1, 0, 1'b0);
    run("after_rst");
    check("after_rst_lit", bus.Result, 32'h001B_FFF9);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/ann_layer.md
ANN_LAYER -- requirements
Module: ann_layer

Interface
REQ-001 SHALL provide parameter N, default 2: number of inputs per neuron (N >= 1).
REQ-002 SHALL provide parameter M, default 2: number of neurons (output channels, M >= 1).
REQ-003 SHALL provide parameter DW, default 8: input, weight and bias element width, signed two's complement.
REQ-004 SHALL provide port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL provide port start, input, 1: request a new evaluation.
REQ-007 SHALL provide port relu_en, input, 1: applies ReLU to outputs when 1; sampled with start.
REQ-008 SHALL provide port InputVec, input, N*DW: element i (0..N-1) is the i-th DW-bit field counted from the MSB end.
REQ-009 SHALL provide port WeightVec, input, M*N*DW: weight for neuron j, input i, is field j*N+i counted from the MSB end.
REQ-010 SHALL provide port BiasVec, input, M*DW: bias j is field j counted from the MSB end.
REQ-011 SHALL provide port Result, output, M*16: signed result j is the 16-bit field j counted from the MSB end.
REQ-012 SHALL provide port ready, output, 1: high when idle and able to accept start.
REQ-013 SHALL provide port done, output, 1: one-cycle pulse when Result is updated.

Function
REQ-014 SHALL implement FSM states IDLE, MAC and OUT.
REQ-015 SHALL drive ready = 1 exactly when the state is IDLE.
REQ-016 In IDLE with start=1, at that edge: capture InputVec, WeightVec, BiasVec and relu_en into internal registers; load acc_j with sign-extended bias j; clear index; go to MAC.
REQ-017 In MAC, each edge: acc_j += x[index]*w[j][index] for all j in parallel (M signed multipliers); increment index.
REQ-018 After the edge processing index N-1: go to OUT; exactly N edges are spent in MAC.
REQ-019 In OUT, at the next edge: register Result for all j; assert done for the following cycle; return to IDLE.
REQ-020 Latency: start sampled at edge t0 -> Result and done updated at edge t0+N+1.
REQ-021 Accumulator width SHALL be 2*DW + clog2(N) + 1 bits, signed; no internal overflow.
REQ-022 Result j = saturate(acc_j) to [-32768, 32767]; then, if the captured relu_en = 1, negative values become 0.
REQ-023 start while not in IDLE SHALL be ignored, with no queueing.
REQ-024 Input port changes after the capture edge SHALL NOT affect the evaluation in progress.
REQ-025 Result SHALL hold its value from one done pulse until the next.
REQ-026 In the cycle where done=1, ready=1 also; start in that cycle SHALL begin a new evaluation (back-to-back, period N+2 cycles).

Reset
REQ-027 rst=1 at any edge SHALL force: state IDLE; Result = 0; done = 0; ready = 1 from the next cycle; accumulators and index cleared.
REQ-028 rst SHALL take priority over start; an evaluation in progress is abandoned with no done pulse.

Verification (N=2, M=2, DW=8)
REQ-029 Basic MAC: x=(3,4), w0=(2,5), b0=1, w1=(-1,-1), b1=0, relu_en=0, start at t0 -> done at t0+3; Result0=27, Result1=-7 (0xFFF9).
REQ-030 ReLU: same vectors with relu_en=1 -> Result0=27, Result1=0.
REQ-031 Saturation: x=(-128,-128), w0=(-128,-128), b0=127 -> Result0=32767 (sum 32895 clamped).
REQ-032 Handshake:
- start pulsed during MAC -> ignored; exactly one done pulse.
- start held high in the done cycle -> second done exactly 4 cycles after the first.
REQ-033 Input capture: change InputVec one cycle after the start edge -> Result reflects the originally captured values.
REQ-034 Reset mid-MAC: assert rst at t0+1 -> no done pulse; Result=0; ready=1 afterwards; a new start then gives correct results.
